// File: rtl/seq_wb_sequencer.sv
// Writeback sequencer for a Y86-64 style core. One request is accepted at a
// time. Its E and M results are written through a single register-file write
// port over one or two cycles, and retirement is signalled with a one-cycle
// done pulse.
// Optional feature: define SEQ_WB_RETCNT_EN to add the 64-bit retired_cnt
// output, which counts done pulses.
module seq_wb_sequencer #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic         cnd,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    output logic         rf_we,
    output logic [3:0]   rf_addr,
    output logic [W-1:0] rf_data,
    output logic [3:0]   dstE,
    output logic [3:0]   dstM,
    output logic         done,
    output logic         halted,
`ifdef SEQ_WB_RETCNT_EN
    output logic         instr_err,
    output logic [63:0]  retired_cnt
`else
    output logic         instr_err
`endif
);

    localparam logic [3:0] RegNone = 4'hF;
    localparam logic [3:0] RegRsp  = 4'h4;

    typedef enum logic [2:0] {StIdle, StWrE, StWrM, StRet, StHalt} state_e;

    state_e         state_q;
    logic [W-1:0]   valm_q;
    logic [3:0]     e_dst;
    logic [3:0]     m_dst;

    // Decode destinations from the request inputs; only used on the accept edge.
    always_comb begin
        e_dst = RegNone;
        m_dst = RegNone;
        unique case (icode)
            4'h2:                   e_dst = cnd ? rB : RegNone;
            4'h3, 4'h6:             e_dst = rB;
            4'h8, 4'h9, 4'hA, 4'hB: e_dst = RegRsp;
            default:                e_dst = RegNone;
        endcase
        if (icode == 4'h5 || icode == 4'hB) begin
            m_dst = rA;
        end
    end

    // Sequencer FSM. All outputs are registered; done rides on the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            valm_q    <= '0;
            in_ready  <= 1'b1;
            rf_we     <= 1'b0;
            rf_addr   <= 4'h0;
            rf_data   <= '0;
            dstE      <= RegNone;
            dstM      <= RegNone;
            done      <= 1'b0;
            halted    <= 1'b0;
            instr_err <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            rf_addr <= 4'h0;
            rf_data <= '0;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (icode == 4'h0 || icode > 4'hB) begin
                            // Halt and illegal codes both stop until reset.
                            state_q   <= StHalt;
                            halted    <= 1'b1;
                            instr_err <= (icode > 4'hB);
                        end else begin
                            valm_q <= valM;
                            dstE   <= e_dst;
                            dstM   <= m_dst;
                            if (e_dst != RegNone) begin
                                state_q <= StWrE;
                                rf_we   <= 1'b1;
                                rf_addr <= e_dst;
                                rf_data <= valE;
                                done    <= (m_dst == RegNone);
                            end else if (m_dst != RegNone) begin
                                state_q <= StWrM;
                                rf_we   <= 1'b1;
                                rf_addr <= m_dst;
                                rf_data <= valM;
                                done    <= 1'b1;
                            end else begin
                                state_q <= StRet;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                StWrE: begin
                    if (dstM != RegNone) begin
                        // Second write goes last so valM wins when both target %rsp.
                        state_q <= StWrM;
                        rf_we   <= 1'b1;
                        rf_addr <= dstM;
                        rf_data <= valm_q;
                        done    <= 1'b1;
                    end else begin
                        state_q  <= StIdle;
                        in_ready <= 1'b1;
                        dstE     <= RegNone;
                        dstM     <= RegNone;
                    end
                end
                StWrM, StRet: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                    dstE     <= RegNone;
                    dstM     <= RegNone;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef SEQ_WB_RETCNT_EN
    // Count retirements; wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= 64'd0;
        end else if (done) begin
            retired_cnt <= retired_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_wb_sequencer.sv
// Scoreboard bench for seq_wb_sequencer: the driver pushes expected
// write/retire cycles and a negedge monitor pops and compares them.
module tb_seq_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  rA = 4'hF;
    logic [3:0]  rB = 4'hF;
    logic        cnd = 1'b0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        done;
    logic        halted;
    logic        instr_err;
`ifdef SEQ_WB_RETCNT_EN
    logic [63:0] retired_cnt;
`endif

    seq_wb_sequencer #(.W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .rA        (rA),
        .rB        (rB),
        .cnd       (cnd),
        .valE      (valE),
        .valM      (valM),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .dstE      (dstE),
        .dstM      (dstM),
        .done      (done),
        .halted    (halted),
`ifdef SEQ_WB_RETCNT_EN
        .instr_err (instr_err),
        .retired_cnt (retired_cnt)
`else
        .instr_err (instr_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [63:0] data;
        logic        done;
        logic [3:0]  de;
        logic [3:0]  dm;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  dones  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every cycle with a write or a retire pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst && (rf_we || done)) begin
            ev_t act;
            act = '{we: rf_we, addr: rf_addr, data: rf_data, done: done, de: dstE, dm: dstM};
            if (done) dones++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %0h expected none", act);
            end else begin
                chk("wb_cycle", act, exp_q.pop_front());
            end
        end
    end

    // Reference model of the writeback sequence for one accepted request.
    task automatic expect_instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                input logic c, input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] e;
        logic [3:0] m;
        e = 4'hF;
        m = 4'hF;
        if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) e = rb;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) e = 4'h4;
        if (ic == 4'h5 || ic == 4'hB) m = ra;
        if (ic == 4'h0 || ic > 4'hB) return;
        if (e != 4'hF) exp_q.push_back('{1'b1, e, ve, (m == 4'hF), e, m});
        if (m != 4'hF) exp_q.push_back('{1'b1, m, vm, 1'b1, e, m});
        if (e == 4'hF && m == 4'hF) exp_q.push_back('{1'b0, 4'h0, 64'h0, 1'b1, e, m});
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm);
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            chk("issue_timeout_in_ready", 80'(in_ready), 80'd1);
            return;
        end
        expect_instr(ic, ra, rb, c, ve, vm);
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 80'(in_ready), 80'd1);
        chk({tag, "_rf"}, {rf_we, rf_addr, rf_data}, 80'd0);
        chk({tag, "_dst"}, {dstE, dstM}, 80'hFF);
        chk({tag, "_flags"}, {done, halted, instr_err}, 80'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs("reset");

        // irmovq rB=3 valE=0x55
        issue(4'h3, 4'hF, 4'h3, 1'b0, 64'h55, 64'h0);

        // popq rA=4: two writes to %rsp, in_ready low for exactly 2 cycles
        issue(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hAB);
        @(negedge clk); chk("popq_busy1", 80'(in_ready), 80'd0);
        @(negedge clk); chk("popq_busy2", 80'(in_ready), 80'd0);
        @(negedge clk); chk("popq_ready", 80'(in_ready), 80'd1);

        // cmovXX not taken then taken
        issue(4'h2, 4'hF, 4'h2, 1'b0, 64'h7, 64'h0);
        issue(4'h2, 4'hF, 4'h2, 1'b1, 64'h7, 64'h0);

        // Assorted decode patterns
        issue(4'h6, 4'h1, 4'h5, 1'b0, 64'h1234, 64'h0);
        issue(4'h5, 4'h6, 4'h1, 1'b0, 64'h10, 64'hDEAD_BEEF);
        issue(4'h8, 4'hF, 4'hF, 1'b0, 64'hFF8, 64'h0);
        issue(4'h9, 4'hF, 4'hF, 1'b0, 64'h1000, 64'h40);
        issue(4'hA, 4'h7, 4'hF, 1'b0, 64'hFF0, 64'h0);
        issue(4'hB, 4'h3, 4'hF, 1'b0, 64'h108, 64'h77);
        issue(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        issue(4'h4, 4'h1, 4'h2, 1'b0, 64'h20, 64'h0);
        issue(4'h7, 4'hF, 4'hF, 1'b1, 64'h0, 64'h0);
        issue(4'h3, 4'hF, 4'hF, 1'b0, 64'h99, 64'h0);
        issue(4'h5, 4'hF, 4'h2, 1'b0, 64'h0, 64'h55);
        issue(4'h3, 4'hF, 4'hE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

        // Wait for the last request to drain, then check the retire count
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("drain_in_ready", 80'(in_ready), 80'd1);
        chk("queue_drained", 80'(exp_q.size()), 80'd0);
`ifdef SEQ_WB_RETCNT_EN
        chk("retired_cnt", retired_cnt, 80'(dones));
`endif

        // Reset during WR_E of popq aborts the WR_M write and the done pulse
        issue(4'hB, 4'h5, 4'hF, 1'b0, 64'h200, 64'hCD);
        void'(exp_q.pop_back());
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outputs("abort");
        repeat (3) @(negedge clk);
        chk("abort_no_wrm", 80'(exp_q.size()), 80'd0);
`ifdef SEQ_WB_RETCNT_EN
        chk("abort_retired_cnt", retired_cnt, 80'd0);
`endif

        // Reset beats a simultaneous accept
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; icode = 4'h3; rB = 4'h6; valE = 64'h11;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_priority_in_ready", 80'(in_ready), 80'd1);
        chk("rst_priority_dst", {dstE, dstM}, 80'hFF);

        // halt, then further requests are ignored
        issue(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        @(negedge clk);
        chk("halt_state", {halted, in_ready, instr_err, done}, 80'b1000);
        chk("halt_dst", {dstE, dstM}, 80'hFF);
        icode = 4'h3; rB = 4'h1; valE = 64'h33; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("halt_hold", {halted, in_ready, instr_err}, 80'b100);
        do_reset();
        chk_reset_outputs("post_halt");

        // Illegal instruction code
        issue(4'hC, 4'h1, 4'h2, 1'b0, 64'h5, 64'h6);
        @(negedge clk);
        chk("illegal_state", {halted, in_ready, instr_err}, 80'b101);
        do_reset();
        chk_reset_outputs("post_illegal");

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 80'(exp_q.size()), 80'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
